// File: rtl/controlador_lote_pkg.sv
// controlador_lote_pkg
// Shared definitions for the bottling-line batch scheduler: FSM state
// encoding, dozen/count limits and the batch-target selection helper.
package controlador_lote_pkg;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    DISPARO     = 3'd1,
    AGUARDA     = 3'd2,
    PAUSA_ROLHA = 3'd3,
    CONCLUIDO   = 3'd4,
    ERRO        = 3'd5
  } estado_t;

  localparam int GARRAFAS_POR_DUZIA = 12;
  localparam int MAX_CONTAGEM       = 99;

  // Last bottle index inside a dozen and the saturation value of the counters
  localparam logic [3:0] ULTIMA_GARRAFA  = 4'(GARRAFAS_POR_DUZIA - 1);
  localparam logic [6:0] LIMITE_CONTAGEM = 7'(MAX_CONTAGEM);

  // Operator target is accepted only in 1..99; anything else falls back to the default
  function automatic logic [6:0] selecionar_alvo(input logic [6:0] alvo,
                                                 input logic [6:0] padrao);
    logic [6:0] resultado;
    if ((alvo != 7'd0) && (alvo <= LIMITE_CONTAGEM)) begin
      resultado = alvo;
    end else begin
      resultado = padrao;
    end
    return resultado;
  endfunction

endpackage

// File: rtl/controlador_lote_watchdog.sv
// temporizador_watchdog
// Per-bottle stall watchdog. Counts enabled cycles since the last clear and
// flags when the count sits at TIMEOUT_CICLOS-1; the counter holds there so
// it never wraps while waiting for the controller to react.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high
//   limpar    in   clear the count (wins over habilitar)
//   habilitar in   count this cycle
//   expirou   out  count has reached TIMEOUT_CICLOS-1
module temporizador_watchdog #(
  parameter int unsigned TIMEOUT_CICLOS = 500000000,
  parameter int          W_TIMEOUT      = 29
) (
  input  logic clk,
  input  logic reset,
  input  logic limpar,
  input  logic habilitar,
  output logic expirou
);

  localparam logic [W_TIMEOUT-1:0] LIMITE = W_TIMEOUT'(TIMEOUT_CICLOS - 32'd1);
  localparam logic [W_TIMEOUT-1:0] UM     = W_TIMEOUT'(1);

  logic [W_TIMEOUT-1:0] contador_r;

  // Cycle counter: clear has priority, counting stops at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      contador_r <= '0;
    end else if (limpar) begin
      contador_r <= '0;
    end else if (habilitar && (contador_r != LIMITE)) begin
      contador_r <= contador_r + UM;
    end else begin
      contador_r <= contador_r;
    end
  end

  assign expirou = (contador_r == LIMITE);

endmodule

// File: rtl/controlador_lote.sv
// controlador_lote
// Batch scheduler for the bottling line. Issues one start pulse per bottle to
// the master sequencer, tallies approved bottles in dozens and rejected
// bottles, stops at the latched target, pauses on cork alarm and flags a
// stalled bottle through the watchdog.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cmd_iniciar_lote      pulse: start a batch (from OCIOSO/CONCLUIDO/ERRO)
//   cmd_abortar           abort the running batch, counters are kept
//   alvo_duzias[6:0]      target dozens, sampled at batch start only
//   mestre_ocioso         master sequencer can accept a start
//   alarme_rolha          cork stock empty
//   pulso_aprovada        bottle finished, approved
//   pulso_reprovada       bottle finished, rejected
//   pulso_start_mestre    one-cycle start to the master sequencer
//   lote_ativo            batch in progress
//   solicita_reposicao    cork refill request
//   lote_concluido        target reached
//   erro_timeout          watchdog expired
//   duzias_produzidas[6:0], garrafas_na_duzia[3:0], reprovadas[6:0]  tallies
// All outputs are registered.
module controlador_lote
  import controlador_lote_pkg::*;
#(
  parameter int          LOTE_DUZIAS    = 10,
  parameter int unsigned TIMEOUT_CICLOS = 500000000,
  parameter int          W_TIMEOUT      = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_iniciar_lote,
  input  logic       cmd_abortar,
  input  logic [6:0] alvo_duzias,
  input  logic       mestre_ocioso,
  input  logic       alarme_rolha,
  input  logic       pulso_aprovada,
  input  logic       pulso_reprovada,
  output logic       pulso_start_mestre,
  output logic       lote_ativo,
  output logic       solicita_reposicao,
  output logic       lote_concluido,
  output logic       erro_timeout,
  output logic [6:0] duzias_produzidas,
  output logic [3:0] garrafas_na_duzia,
  output logic [6:0] reprovadas
);

  localparam logic [6:0] ALVO_PADRAO = 7'(LOTE_DUZIAS);

  estado_t    estado_r, estado_s;
  logic [3:0] garrafas_r, garrafas_s;
  logic [6:0] duzias_r, duzias_s;
  logic [6:0] reprovadas_r, reprovadas_s;
  logic [6:0] alvo_r, alvo_s;

  logic pulso_start_r;
  logic lote_ativo_r;
  logic solicita_r;
  logic concluido_r;
  logic erro_r;

  logic expirou_s;
  logic limpar_s;
  logic habilitar_s;

  // Watchdog runs only while a bottle is in flight and restarts on every entry to AGUARDA
  always_comb begin
    limpar_s    = (estado_r != AGUARDA);
    habilitar_s = (estado_r == AGUARDA);
  end

  temporizador_watchdog #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .W_TIMEOUT      (W_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .limpar    (limpar_s),
    .habilitar (habilitar_s),
    .expirou   (expirou_s)
  );

  // Next-state and next-counter logic
  always_comb begin
    estado_s     = estado_r;
    garrafas_s   = garrafas_r;
    duzias_s     = duzias_r;
    reprovadas_s = reprovadas_r;
    alvo_s       = alvo_r;

    if (cmd_abortar) begin
      // Abort outranks every other event; it also blocks a start while idle
      if (estado_r != OCIOSO) begin
        estado_s = OCIOSO;
      end else begin
        estado_s = estado_r;
      end
    end else begin
      case (estado_r)
        OCIOSO, CONCLUIDO, ERRO: begin
          if (cmd_iniciar_lote) begin
            alvo_s       = selecionar_alvo(alvo_duzias, ALVO_PADRAO);
            garrafas_s   = 4'd0;
            duzias_s     = 7'd0;
            reprovadas_s = 7'd0;
            estado_s     = DISPARO;
          end else begin
            estado_s = estado_r;
          end
        end

        DISPARO: begin
          if (alarme_rolha) begin
            estado_s = PAUSA_ROLHA;
          end else if (mestre_ocioso) begin
            estado_s = AGUARDA;
          end else begin
            estado_s = DISPARO;
          end
        end

        AGUARDA: begin
          // Approval beats rejection, and any result beats the watchdog
          if (pulso_aprovada) begin
            if (garrafas_r == ULTIMA_GARRAFA) begin
              garrafas_s = 4'd0;
              duzias_s   = duzias_r + 7'd1;
              if (duzias_s == alvo_r) begin
                estado_s = CONCLUIDO;
              end else begin
                estado_s = DISPARO;
              end
            end else begin
              garrafas_s = garrafas_r + 4'd1;
              estado_s   = DISPARO;
            end
          end else if (pulso_reprovada) begin
            if (reprovadas_r < LIMITE_CONTAGEM) begin
              reprovadas_s = reprovadas_r + 7'd1;
            end else begin
              reprovadas_s = reprovadas_r;
            end
            estado_s = DISPARO;
          end else if (expirou_s) begin
            estado_s = ERRO;
          end else begin
            estado_s = AGUARDA;
          end
        end

        PAUSA_ROLHA: begin
          if (!alarme_rolha) begin
            estado_s = DISPARO;
          end else begin
            estado_s = PAUSA_ROLHA;
          end
        end

        default: begin
          estado_s = OCIOSO;
        end
      endcase
    end
  end

  // State, counters and registered outputs (outputs decoded from the next state)
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r      <= OCIOSO;
      garrafas_r    <= 4'd0;
      duzias_r      <= 7'd0;
      reprovadas_r  <= 7'd0;
      alvo_r        <= ALVO_PADRAO;
      pulso_start_r <= 1'b0;
      lote_ativo_r  <= 1'b0;
      solicita_r    <= 1'b0;
      concluido_r   <= 1'b0;
      erro_r        <= 1'b0;
    end else begin
      estado_r      <= estado_s;
      garrafas_r    <= garrafas_s;
      duzias_r      <= duzias_s;
      reprovadas_r  <= reprovadas_s;
      alvo_r        <= alvo_s;
      // High exactly during the first AGUARDA cycle
      pulso_start_r <= (estado_r == DISPARO) && (estado_s == AGUARDA);
      lote_ativo_r  <= (estado_s == DISPARO) || (estado_s == AGUARDA) ||
                       (estado_s == PAUSA_ROLHA);
      solicita_r    <= (estado_s == PAUSA_ROLHA);
      concluido_r   <= (estado_s == CONCLUIDO);
      erro_r        <= (estado_s == ERRO);
    end
  end

  assign pulso_start_mestre = pulso_start_r;
  assign lote_ativo         = lote_ativo_r;
  assign solicita_reposicao = solicita_r;
  assign lote_concluido     = concluido_r;
  assign erro_timeout       = erro_r;
  assign duzias_produzidas  = duzias_r;
  assign garrafas_na_duzia  = garrafas_r;
  assign reprovadas         = reprovadas_r;

endmodule

// File: tb/tb_controlador_lote.sv
// Bench for controlador_lote: batch-level vector table plus hand-written
// sequences for pause, watchdog, abort and reset. Counter updates are checked
// against a scoreboard filled whenever a result pulse is driven.
module tb_controlador_lote;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_iniciar_lote;
  logic       cmd_abortar;
  logic [6:0] alvo_duzias;
  logic       mestre_ocioso;
  logic       alarme_rolha;
  logic       pulso_aprovada;
  logic       pulso_reprovada;
  logic       pulso_start_mestre;
  logic       lote_ativo;
  logic       solicita_reposicao;
  logic       lote_concluido;
  logic       erro_timeout;
  logic [6:0] duzias_produzidas;
  logic [3:0] garrafas_na_duzia;
  logic [6:0] reprovadas;

  always #5 clk = ~clk;

  controlador_lote #(
    .LOTE_DUZIAS    (10),
    .TIMEOUT_CICLOS (20),
    .W_TIMEOUT      (5)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_iniciar_lote   (cmd_iniciar_lote),
    .cmd_abortar        (cmd_abortar),
    .alvo_duzias        (alvo_duzias),
    .mestre_ocioso      (mestre_ocioso),
    .alarme_rolha       (alarme_rolha),
    .pulso_aprovada     (pulso_aprovada),
    .pulso_reprovada    (pulso_reprovada),
    .pulso_start_mestre (pulso_start_mestre),
    .lote_ativo         (lote_ativo),
    .solicita_reposicao (solicita_reposicao),
    .lote_concluido     (lote_concluido),
    .erro_timeout       (erro_timeout),
    .duzias_produzidas  (duzias_produzidas),
    .garrafas_na_duzia  (garrafas_na_duzia),
    .reprovadas         (reprovadas)
  );

  typedef struct {
    int duz;
    int garr;
    int rep;
  } esperado_t;

  typedef struct {
    logic [6:0] alvo;
    int n_aprov;
    int n_rej;
    int n_ambos;
    int e_duz;
    int e_garr;
    int e_rep;
    int e_concl;
    int e_ativo;
    int e_starts;
  } vetor_t;

  esperado_t sb[$];
  vetor_t    tab[7];

  int total = 0;
  int bad   = 0;
  int n_starts = 0;
  bit pulso_anterior = 1'b0;

  // Reference tallies: totals since batch start, dozens derived arithmetically
  int m_aprov = 0;
  int m_rej   = 0;

  task automatic verificar(input string nome, input int atual, input int esperado);
    total++;
    if (atual != esperado) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic modelo_resultado(input bit a, input bit r, input bit conta);
    esperado_t e;
    if (conta && a) m_aprov++;
    else if (conta && r) m_rej++;
    e.duz  = m_aprov / 12;
    e.garr = m_aprov % 12;
    e.rep  = (m_rej > 99) ? 99 : m_rej;
    sb.push_back(e);
  endtask

  task automatic esperar_start(input int limite, input string nome);
    bit visto = 1'b0;
    for (int k = 0; k < limite; k++) begin
      tick();
      if (pulso_start_mestre) begin
        visto = 1'b1;
        break;
      end
    end
    verificar(nome, int'(visto), 1);
  endtask

  // Result pulse sampled on the 5th edge after the edge that raised the start pulse
  task automatic responder(input bit a, input bit r, input bit conta);
    repeat (4) tick();
    pulso_aprovada  = a;
    pulso_reprovada = r;
    modelo_resultado(a, r, conta);
    tick();
    pulso_aprovada  = 1'b0;
    pulso_reprovada = 1'b0;
  endtask

  task automatic iniciar(input logic [6:0] alvo, input bit abortar_antes);
    if (abortar_antes) begin
      cmd_abortar = 1'b1;
      tick();
      cmd_abortar = 1'b0;
    end
    alvo_duzias      = alvo;
    cmd_iniciar_lote = 1'b1;
    tick();
    cmd_iniciar_lote = 1'b0;
    alvo_duzias      = 7'd3;
    m_aprov = 0;
    m_rej   = 0;
    verificar("inicio_ativo", int'(lote_ativo), 1);
    verificar("inicio_concluido", int'(lote_concluido), 0);
    verificar("inicio_erro", int'(erro_timeout), 0);
    verificar("inicio_duzias", int'(duzias_produzidas), 0);
    verificar("inicio_garrafas", int'(garrafas_na_duzia), 0);
    verificar("inicio_reprovadas", int'(reprovadas), 0);
  endtask

  // Remember whether the DUT sampled a result pulse on this edge
  initial forever begin
    @(posedge clk);
    pulso_anterior = pulso_aprovada | pulso_reprovada;
  end

  // Count start pulses and compare counters after every sampled result pulse
  initial forever begin
    esperado_t e;
    @(negedge clk);
    if (pulso_start_mestre) n_starts++;
    if (pulso_anterior) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_vazio: result pulse with no expected entry");
      end else begin
        e = sb.pop_front();
        verificar("sb_duzias", int'(duzias_produzidas), e.duz);
        verificar("sb_garrafas", int'(garrafas_na_duzia), e.garr);
        verificar("sb_reprovadas", int'(reprovadas), e.rep);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int s0;
    tab[0] = '{7'd1,   12,   0,   0, 1,  0,  0,  1, 0, 12};
    tab[1] = '{7'd0,   119,  0,   0, 9,  11, 0,  0, 1, 119};
    tab[2] = '{7'd0,   120,  0,   0, 10, 0,  0,  1, 0, 120};
    tab[3] = '{7'd5,   2,    1,   2, 0,  4,  1,  0, 1, 5};
    tab[4] = '{7'd100, 13,   0,   0, 1,  1,  0,  0, 1, 13};
    tab[5] = '{7'd0,   0,    105, 0, 0,  0,  99, 0, 1, 105};
    tab[6] = '{7'd99,  1188, 0,   0, 99, 0,  0,  1, 0, 1188};

    reset            = 1'b1;
    cmd_iniciar_lote = 1'b0;
    cmd_abortar      = 1'b0;
    alvo_duzias      = 7'd0;
    mestre_ocioso    = 1'b0;
    alarme_rolha     = 1'b0;
    pulso_aprovada   = 1'b0;
    pulso_reprovada  = 1'b0;
    tick();
    tick();
    verificar("rst_start", int'(pulso_start_mestre), 0);
    verificar("rst_ativo", int'(lote_ativo), 0);
    verificar("rst_solicita", int'(solicita_reposicao), 0);
    verificar("rst_concluido", int'(lote_concluido), 0);
    verificar("rst_erro", int'(erro_timeout), 0);
    verificar("rst_duzias", int'(duzias_produzidas), 0);
    verificar("rst_garrafas", int'(garrafas_na_duzia), 0);
    verificar("rst_reprovadas", int'(reprovadas), 0);
    reset         = 1'b0;
    mestre_ocioso = 1'b1;
    tick();

    // Batch-level vectors
    for (int i = 0; i < 7; i++) begin
      iniciar(tab[i].alvo, 1'b1);
      s0 = n_starts;
      for (int k = 0; k < tab[i].n_aprov; k++) begin
        esperar_start(10, "vet_start");
        responder(1'b1, 1'b0, 1'b1);
      end
      for (int k = 0; k < tab[i].n_rej; k++) begin
        esperar_start(10, "vet_start");
        responder(1'b0, 1'b1, 1'b1);
      end
      for (int k = 0; k < tab[i].n_ambos; k++) begin
        esperar_start(10, "vet_start");
        responder(1'b1, 1'b1, 1'b1);
      end
      verificar("vet_duzias", int'(duzias_produzidas), tab[i].e_duz);
      verificar("vet_garrafas", int'(garrafas_na_duzia), tab[i].e_garr);
      verificar("vet_reprovadas", int'(reprovadas), tab[i].e_rep);
      verificar("vet_concluido", int'(lote_concluido), tab[i].e_concl);
      verificar("vet_ativo", int'(lote_ativo), tab[i].e_ativo);
      verificar("vet_starts", n_starts - s0, tab[i].e_starts);
      if (tab[i].e_concl != 0) begin
        repeat (8) tick();
        verificar("vet_sem_start_extra", n_starts - s0, tab[i].e_starts);
      end
    end

    // Cork pause: no dispatch while alarmed, result pulses ignored
    alarme_rolha = 1'b1;
    iniciar(7'd3, 1'b1);
    tick();
    s0 = n_starts;
    repeat (3) tick();
    verificar("pausa_solicita", int'(solicita_reposicao), 1);
    verificar("pausa_ativo", int'(lote_ativo), 1);
    verificar("pausa_sem_start", n_starts - s0, 0);
    pulso_aprovada = 1'b1;
    modelo_resultado(1'b1, 1'b0, 1'b0);
    tick();
    pulso_aprovada = 1'b0;
    tick();
    alarme_rolha = 1'b0;
    esperar_start(2, "pausa_start_2ciclos");
    verificar("pausa_solicita_off", int'(solicita_reposicao), 0);
    // Alarm raised with a bottle in flight only pauses the next dispatch
    alarme_rolha = 1'b1;
    responder(1'b1, 1'b0, 1'b1);
    s0 = n_starts;
    tick();
    verificar("pausa_apos_garrafa", int'(solicita_reposicao), 1);
    tick();
    verificar("pausa_apos_sem_start", n_starts - s0, 0);
    alarme_rolha = 1'b0;

    // Watchdog: 20 silent cycles expire, restart clears, result on cycle 19 wins
    iniciar(7'd1, 1'b1);
    esperar_start(10, "to_start");
    responder(1'b0, 1'b1, 1'b1);
    esperar_start(10, "to_start");
    responder(1'b1, 1'b0, 1'b1);
    esperar_start(10, "to_start");
    repeat (19) tick();
    verificar("to_erro_ainda_nao", int'(erro_timeout), 0);
    verificar("to_ativo_ainda", int'(lote_ativo), 1);
    tick();
    verificar("to_erro", int'(erro_timeout), 1);
    verificar("to_ativo_off", int'(lote_ativo), 0);
    s0 = n_starts;
    repeat (3) tick();
    verificar("to_sem_start", n_starts - s0, 0);
    iniciar(7'd1, 1'b0);
    esperar_start(10, "to_retoma");
    repeat (19) tick();
    pulso_aprovada = 1'b1;
    modelo_resultado(1'b1, 1'b0, 1'b1);
    tick();
    pulso_aprovada = 1'b0;
    verificar("to_ciclo19_sem_erro", int'(erro_timeout), 0);
    verificar("to_ciclo19_ativo", int'(lote_ativo), 1);
    tick();
    verificar("to_ciclo19_sem_erro2", int'(erro_timeout), 0);

    // Master busy holds dispatch; abort mid-AGUARDA keeps counters
    mestre_ocioso = 1'b0;
    iniciar(7'd3, 1'b1);
    s0 = n_starts;
    repeat (5) tick();
    verificar("ocupado_sem_start", n_starts - s0, 0);
    verificar("ocupado_ativo", int'(lote_ativo), 1);
    mestre_ocioso = 1'b1;
    esperar_start(2, "ocupado_start");
    responder(1'b1, 1'b0, 1'b1);
    esperar_start(10, "ab_start");
    responder(1'b1, 1'b0, 1'b1);
    esperar_start(10, "ab_start");
    cmd_abortar = 1'b1;
    tick();
    cmd_abortar = 1'b0;
    verificar("ab_ativo", int'(lote_ativo), 0);
    verificar("ab_garrafas", int'(garrafas_na_duzia), 2);
    s0 = n_starts;
    pulso_aprovada = 1'b1;
    modelo_resultado(1'b1, 1'b0, 1'b0);
    tick();
    pulso_aprovada = 1'b0;
    repeat (4) tick();
    verificar("ab_sem_start", n_starts - s0, 0);
    verificar("ab_garrafas_mantidas", int'(garrafas_na_duzia), 2);

    // Reset mid-batch
    iniciar(7'd3, 1'b1);
    esperar_start(10, "rst2_start");
    responder(1'b0, 1'b1, 1'b1);
    esperar_start(10, "rst2_start");
    responder(1'b1, 1'b0, 1'b1);
    esperar_start(10, "rst2_start");
    reset = 1'b1;
    tick();
    verificar("rst2_start_out", int'(pulso_start_mestre), 0);
    verificar("rst2_ativo", int'(lote_ativo), 0);
    verificar("rst2_solicita", int'(solicita_reposicao), 0);
    verificar("rst2_concluido", int'(lote_concluido), 0);
    verificar("rst2_erro", int'(erro_timeout), 0);
    verificar("rst2_duzias", int'(duzias_produzidas), 0);
    verificar("rst2_garrafas", int'(garrafas_na_duzia), 0);
    verificar("rst2_reprovadas", int'(reprovadas), 0);
    reset = 1'b0;
    tick();

    verificar("sb_restante", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controlador_lote.md
Name: controlador_lote

Overview:
- Batch scheduler for the bottling line.
- Sequences the master sequencer one bottle at a time by issuing single-cycle start pulses, tallies approved and rejected bottles, and stops when a target number of dozens is reached.
- Pauses dispatch while the cork alarm is active and raises a cork refill request.
- Runs a per-bottle watchdog and flags a stalled line.
- Sits between the debounced START/abort inputs and the master sequencer's start input.

Parameters:
- LOTE_DUZIAS, 10, default target in dozens, used when alvo_duzias is 0 or greater than 99.
- TIMEOUT_CICLOS, 500000000, maximum clk cycles allowed per bottle (10 s at 50 MHz).
- W_TIMEOUT, 29, width of the watchdog counter; must satisfy 2^W_TIMEOUT > TIMEOUT_CICLOS.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- cmd_iniciar_lote  in  1  one-cycle pulse that starts a batch
- cmd_abortar  in  1  level or pulse that aborts the batch
- alvo_duzias  in  7  target dozens, sampled only at batch start
- mestre_ocioso  in  1  master sequencer is idle and can accept a start
- alarme_rolha  in  1  cork stock empty
- pulso_aprovada  in  1  one-cycle pulse: bottle finished and approved
- pulso_reprovada  in  1  one-cycle pulse: bottle finished and rejected
- pulso_start_mestre  out  1  one-cycle start pulse to the master sequencer
- lote_ativo  out  1  batch in progress (DISPARO, AGUARDA or PAUSA_ROLHA)
- solicita_reposicao  out  1  cork refill request
- lote_concluido  out  1  batch reached its target
- erro_timeout  out  1  watchdog expired
- duzias_produzidas  out  7  completed dozens, 0..99
- garrafas_na_duzia  out  4  approved bottles in the current dozen, 0..11
- reprovadas  out  7  rejected bottles, saturates at 99

Behaviour:
- Reset: all outputs are 0, all counters are 0, state is OCIOSO, and the latched target is LOTE_DUZIAS.
- Outputs are registered.
- States: OCIOSO, DISPARO, AGUARDA, PAUSA_ROLHA, CONCLUIDO, ERRO.
- Priority, highest first: reset > cmd_abortar > all other events.
- cmd_abortar in any state other than OCIOSO: go to OCIOSO next cycle; counters are held; lote_concluido and erro_timeout are cleared.
- OCIOSO, CONCLUIDO, ERRO on cmd_iniciar_lote:
  - latch the target: alvo_duzias if it is 1..99, otherwise LOTE_DUZIAS;
  - clear all three counters, lote_concluido and erro_timeout;
  - go to DISPARO.
- cmd_iniciar_lote is ignored in DISPARO, AGUARDA and PAUSA_ROLHA.
- DISPARO:
  - if alarme_rolha is 1, go to PAUSA_ROLHA;
  - else if mestre_ocioso is 1, go to AGUARDA and pulse pulso_start_mestre for exactly the first cycle in AGUARDA; the watchdog clears on entry;
  - otherwise stay in DISPARO.
- AGUARDA:
  - the watchdog increments every cycle;
  - on pulso_aprovada: garrafas_na_duzia increments. At 11→12 it wraps to 0 and duzias_produzidas increments. If the new dozen count equals the target, go to CONCLUIDO; otherwise go to DISPARO.
  - on pulso_reprovada: reprovadas increments, saturating at 99, and the state goes to DISPARO.
  - if pulso_aprovada and pulso_reprovada arrive in the same cycle, only the approval counts.
  - alarme_rolha is ignored here because the bottle is already in flight; the pause decision is made only in DISPARO.
  - if the watchdog reaches TIMEOUT_CICLOS-1 with no result pulse, go to ERRO. A result pulse in that same cycle wins over the timeout.
- PAUSA_ROLHA: solicita_reposicao is 1; when alarme_rolha returns to 0, go to DISPARO. Pulses of pulso_aprovada or pulso_reprovada in this state are ignored.
- CONCLUIDO: lote_concluido is 1; counters are held for display.
- ERRO: erro_timeout is 1; no start pulses are issued.
- Result pulses arriving in OCIOSO, DISPARO, CONCLUIDO or ERRO are ignored.
- Latency: at most 1 cycle from cmd_iniciar_lote to the DISPARO state; the start pulse is 1 cycle after DISPARO sees mestre_ocioso=1.

Decomposition:
- Shared package holds:
  - state encoding;
  - GARRAFAS_POR_DUZIA = 12;
  - MAX_CONTAGEM = 99.
- One sub-module, temporizador_watchdog:
  - inputs: clk, reset, limpar, habilitar;
  - output: expirou;
  - parameters: TIMEOUT_CICLOS, W_TIMEOUT.

Test Plan:
- TIMEOUT_CICLOS=20, alvo_duzias=1, mestre_ocioso=1, 12 pulso_aprovada each 5 cycles after its start pulse → 12 start pulses, duzias_produzidas=1, garrafas_na_duzia=0, lote_concluido=1, no 13th start pulse.
- alvo_duzias=0 → target is LOTE_DUZIAS=10; after 119 approvals duzias_produzidas=9, garrafas_na_duzia=11, lote_ativo=1; the 120th approval sets lote_concluido=1.
- alarme_rolha=1 in DISPARO → solicita_reposicao=1 and no start pulse; release alarme_rolha → start pulse within 2 cycles, solicita_reposicao=0.
- No result pulse for 20 cycles → erro_timeout=1, lote_ativo=0; a later cmd_iniciar_lote clears counters and resumes dispatch. A result pulse on cycle 19 → no error.
- Approve and reject in the same cycle → garrafas_na_duzia +1, reprovadas unchanged. 105 rejections → reprovadas=99.
- cmd_abortar mid-AGUARDA → OCIOSO next cycle, counters held. reset asserted mid-batch → all outputs 0 on the next clock edge.
